// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner encoding
// and latency counter width.
package mem_arb_pkg;

    localparam int unsigned LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of mem_port_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              dm_stall;

    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
               mem_ren, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
               mem_ren, mem_wen, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and data requests.
// ARB_ROUND_ROBIN_EN: ties go to the requester not granted most recently.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   dm_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_t last_own,
`endif
    output logic   any_req,
    output owner_t grant
);

    always_comb begin
        any_req = if_req | dm_req;
        grant   = dm_req ? OWN_DM : OWN_IF;
`ifdef ARB_ROUND_ROBIN_EN
        if (if_req && dm_req) begin
            grant = (last_own == OWN_DM) ? OWN_IF : OWN_DM;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between IF and MEM stages.
// Optional ARB_ROUND_ROBIN_EN selects round-robin instead of dm-first priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    state_t                 state_q, state_d;
    owner_t                 own_q, own_d;
    logic                   we_q, we_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]      dm_rdata_q, dm_rdata_d;

    logic                   pick_any;
    owner_t                 pick_own;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t                 ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_IDLE && pick_any) begin
            ptr_d = pick_own;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= OWN_IF;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    mem_arb_pick u_pick (
        .if_req   (bus.if_req),
        .dm_req   (bus.dm_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_own (ptr_q),
`endif
        .any_req  (pick_any),
        .grant    (pick_own)
    );

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_ISSUE;
                    own_d   = pick_own;
                    if (pick_own == OWN_DM) begin
                        we_d    = bus.dm_we;
                        addr_d  = bus.dm_addr;
                        wdata_d = bus.dm_wdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = bus.if_addr;
                        wdata_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = LAT_CNT_W'(MEM_LATENCY - 1);
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    // Read data lands only in the owner's register; writes leave both alone.
                    if (!we_q) begin
                        if (own_q == OWN_DM) begin
                            dm_rdata_d = bus.mem_rdata;
                        end else begin
                            if_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            own_q      <= OWN_IF;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.mem_ren   = (state_q == ST_ISSUE) && !we_q;
    assign bus.mem_wen   = (state_q == ST_ISSUE) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ack    = (state_q == ST_RESP) && (own_q == OWN_IF);
    assign bus.dm_ack    = (state_q == ST_RESP) && (own_q == OWN_DM);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_stall  = bus.if_req & ~bus.if_ack;
    assign bus.dm_stall  = bus.dm_req & ~bus.dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner sequences and
// a randomized run against a transaction-level timing model.
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 3;

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_own;
        logic [31:0] exp_other;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    logic mem_init;
    logic last_own;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    logic [31:0] mem    [64];
    logic [31:0] mem1   [64];
    logic [31:0] shadow [64];
    logic [31:0] pipe   [LAT];
    logic [31:0] pipe1;

    always #5 clock = ~clock;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h8C22_0004;
        return 32'(32'hA500_0000 + i * 7919);
    endfunction

    // Expected owner for a grant: 1 = data stage, 0 = fetch.
    function automatic logic pick_rule(input logic ir, input logic dr, input logic last);
`ifdef ARB_ROUND_ROBIN_EN
        if (ir && dr) return ~last;
`else
        if (ir && dr) return 1'b1;
`endif
        return dr;
    endfunction

    // Fixed-latency memories: read data valid LAT edges after the strobe edge.
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (bus.mem_wen) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
        pipe[0] <= bus.mem_ren ? mem[bus.mem_addr[7:2]] : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem1[i] <= init_word(i);
        end else if (bus1.mem_wen) begin
            mem1[bus1.mem_addr[7:2]] <= bus1.mem_wdata;
        end
        pipe1 <= bus1.mem_ren ? mem1[bus1.mem_addr[7:2]] : 32'hBAD0_BAD0;
    end
    assign bus1.mem_rdata = pipe1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req  = 1'b0; bus.if_addr  = '0; bus.dm_req  = 1'b0;
        bus.dm_we   = 1'b0; bus.dm_addr  = '0; bus.dm_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.dm_req = 1'b0;
        bus1.dm_we  = 1'b0; bus1.dm_addr = '0; bus1.dm_wdata = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // One access on the main port; returns at the negedge of the ack cycle.
    task automatic do_access(input vec_t v, output int lat, output int n_ren, output int n_wen,
                             output int n_other, output logic [31:0] saddr, output logic [31:0] swdata);
        lat = -1; n_ren = 0; n_wen = 0; n_other = 0; saddr = '0; swdata = '0;
        if (v.is_dm) begin
            bus.dm_req = 1'b1; bus.dm_we = v.we; bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clock);
            if (bus.mem_ren) n_ren++;
            if (bus.mem_wen) n_wen++;
            if (bus.mem_ren || bus.mem_wen) begin saddr = bus.mem_addr; swdata = bus.mem_wdata; end
            if (v.is_dm ? bus.if_ack : bus.dm_ack) n_other++;
            if (v.is_dm ? bus.dm_ack : bus.if_ack) lat = k;
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
    endtask

    task automatic rand_phase(input int ncyc);
        int c, g;
        logic busy, own, we, if_pend, dm_pend;
        logic e_ren, e_wen, e_ifack, e_dmack;
        logic [31:0] a, wd, e_addr, e_wdata, e_ifrd, e_dmrd;
        pulse_reset();
        last_own = 1'b0;
        c = 0; g = 0; busy = 0; own = 0; we = 0; a = '0; wd = '0; if_pend = 0; dm_pend = 0;
        e_addr = '0; e_wdata = '0; e_ifrd = '0; e_dmrd = '0;
        repeat (ncyc) begin
            @(negedge clock);
            c++;
            if (busy && c == g) begin
                e_addr = a; e_wdata = wd;
                if (we) shadow[a[7:2]] = wd;
            end
            e_ren   = busy && c == g && !we;
            e_wen   = busy && c == g && we;
            e_ifack = busy && c == g + int'(LAT) + 1 && !own;
            e_dmack = busy && c == g + int'(LAT) + 1 && own;
            if (e_ifack) e_ifrd = shadow[a[7:2]];
            if (e_dmack && !we) e_dmrd = shadow[a[7:2]];
            check("rnd_ctl", {26'd0, bus.mem_ren, bus.mem_wen, bus.if_ack, bus.dm_ack, bus.if_stall, bus.dm_stall},
                  {26'd0, e_ren, e_wen, e_ifack, e_dmack, bus.if_req & ~e_ifack, bus.dm_req & ~e_dmack});
            check("rnd_addr", bus.mem_addr, e_addr);
            check("rnd_wdata", bus.mem_wdata, e_wdata);
            check("rnd_if_rdata", bus.if_rdata, e_ifrd);
            check("rnd_dm_rdata", bus.dm_rdata, e_dmrd);
            if (e_ifack) if_pend = 0;
            if (e_dmack) dm_pend = 0;
            if (!if_pend) begin
                if ($urandom_range(0, 2) == 0) begin
                    if_pend = 1; bus.if_req = 1'b1;
                    bus.if_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                end else bus.if_req = 1'b0;
            end
            if (!dm_pend) begin
                if ($urandom_range(0, 2) == 0) begin
                    dm_pend = 1; bus.dm_req = 1'b1; bus.dm_we = 1'($urandom_range(0, 1));
                    bus.dm_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                    bus.dm_wdata = $urandom;
                end else bus.dm_req = 1'b0;
            end
            // Next grant can happen at the earliest LAT+3 edges after the previous one.
            if (busy && c >= g + int'(LAT) + 2) busy = 0;
            if (!busy && (bus.if_req || bus.dm_req)) begin
                own = pick_rule(bus.if_req, bus.dm_req, last_own);
                last_own = own;
                we = own & bus.dm_we;
                a  = own ? bus.dm_addr : bus.if_addr;
                wd = own ? bus.dm_wdata : 32'd0;
                g = c + 1; busy = 1;
            end
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        repeat (2 * (LAT + 3)) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tab [6];
        int lat, nr, nw, no, k_if, k_dm, gap, n;
        logic [31:0] sa, sw;
        int   t_ack [6];
        logic o_ack [6];
        logic exp_o;

        tab[0] = '{1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0,         32'h0};
        tab[1] = '{1'b0, 1'b0, 32'h40, 32'h0,         32'hDEAD_BEEF, 32'h0};
        tab[2] = '{1'b1, 1'b0, 32'h40, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tab[3] = '{1'b1, 1'b1, 32'h44, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tab[4] = '{1'b0, 1'b0, 32'h44, 32'h0,         32'h1234_5678, 32'hDEAD_BEEF};
        tab[5] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h8C22_0004, 32'h1234_5678};

        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        idle_inputs();
        mem_init = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_ctl", {26'd0, bus.mem_ren, bus.mem_wen, bus.if_ack, bus.dm_ack, bus.if_stall, bus.dm_stall}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_rdata", bus.if_rdata | bus.dm_rdata, 32'd0);
        check("rst1_ctl", {28'd0, bus1.mem_ren, bus1.mem_wen, bus1.if_ack, bus1.dm_ack}, 32'd0);
        mem_init = 1'b0;
        reset = 1'b0;
        @(negedge clock);

        // Directed table on the LAT=3 port.
        for (int i = 0; i < 6; i++) begin
            do_access(tab[i], lat, nr, nw, no, sa, sw);
            check("tab_latency", 32'(lat), LAT + 2);
            check("tab_strobes", {nr[15:0], nw[15:0]}, tab[i].we ? 32'h0000_0001 : 32'h0001_0000);
            check("tab_other_ack", 32'(no), 32'd0);
            check("tab_mem_addr", sa, tab[i].addr);
            if (tab[i].we) begin
                check("tab_mem_wdata", sw, tab[i].wdata);
                shadow[tab[i].addr[7:2]] = tab[i].wdata;
            end
            check("tab_own_rdata", tab[i].is_dm ? bus.dm_rdata : bus.if_rdata, tab[i].exp_own);
            check("tab_other_rdata", tab[i].is_dm ? bus.if_rdata : bus.dm_rdata, tab[i].exp_other);
            @(negedge clock);
        end
        check("mem_0x40", mem[16], 32'hDEAD_BEEF);

        // Fetch on the LAT=1 port.
        bus1.if_req = 1'b1; bus1.if_addr = 32'h10;
        k_if = -1; nr = 0; sa = '0; no = 0;
        for (int k = 1; k <= 10 && k_if < 0; k++) begin
            @(negedge clock);
            if (bus1.mem_ren) begin nr++; sa = bus1.mem_addr; end
            if (bus1.dm_ack) no++;
            if (bus1.if_ack) begin
                k_if = k;
                check("l1_stall_at_ack", 32'(bus1.if_stall), 32'd0);
            end else check("l1_stall_wait", 32'(bus1.if_stall), 32'd1);
        end
        bus1.if_req = 1'b0;
        check("l1_latency", 32'(k_if), 32'd3);
        check("l1_ren_count", 32'(nr), 32'd1);
        check("l1_ren_addr", sa, 32'h10);
        check("l1_dm_ack", 32'(no), 32'd0);
        check("l1_if_rdata", bus1.if_rdata, 32'h8C22_0004);
        @(negedge clock);

        // Simultaneous requests on the LAT=1 port: dm first, fetch 4 cycles later.
        bus1.if_req = 1'b1; bus1.if_addr = 32'h10;
        bus1.dm_req = 1'b1; bus1.dm_we = 1'b0; bus1.dm_addr = 32'h14;
        k_if = -1; k_dm = -1; gap = 0;
        for (int k = 1; k <= 30 && k_if < 0; k++) begin
            @(negedge clock);
            if (bus1.dm_ack && k_dm < 0) begin k_dm = k; bus1.dm_req = 1'b0; end
            if (bus1.if_ack) k_if = k;
            else if (!bus1.if_stall) gap++;
        end
        bus1.if_req = 1'b0; bus1.dm_req = 1'b0;
        check("both_dm_ack", 32'(k_dm), 32'd3);
        check("both_if_ack", 32'(k_if), 32'd7);
        check("both_if_stall", 32'(gap), 32'd0);
        check("both_dm_rdata", bus1.dm_rdata, init_word(5));

        // Both requesters held for six accesses.
        pulse_reset();
        last_own = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h4;
        n = 0;
        for (int k = 1; k <= 100 && n < 6; k++) begin
            @(negedge clock);
            if (bus.if_ack || bus.dm_ack) begin
                t_ack[n] = k; o_ack[n] = bus.dm_ack; n++;
            end
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        check("hold_ack_count", 32'(n), 32'd6);
        for (int i = 0; i < n; i++) begin
            exp_o = pick_rule(1'b1, 1'b1, last_own);
            last_own = exp_o;
            check("hold_owner", 32'(o_ack[i]), 32'(exp_o));
            check("hold_spacing", 32'(t_ack[i]), 32'((LAT + 2) + i * (LAT + 3)));
        end
        repeat (LAT + 4) @(negedge clock);

        rand_phase(800);

        // Reset during WAIT of a read.
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        repeat (2) @(negedge clock);
        reset = 1'b1; bus.if_req = 1'b0;
        #1;
        check("rmid_ctl", {28'd0, bus.mem_ren, bus.mem_wen, bus.if_ack, bus.dm_ack}, 32'd0);
        check("rmid_addr", bus.mem_addr, 32'd0);
        check("rmid_rdata", bus.if_rdata | bus.dm_rdata | bus.mem_wdata, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clock);
            if (bus.if_ack || bus.dm_ack || bus.mem_ren || bus.mem_wen) n++;
        end
        check("rmid_quiet", 32'(n), 32'd0);
        do_access('{1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'h0}, lat, nr, nw, no, sa, sw);
        check("rmid_fresh_lat", 32'(lat), LAT + 2);
        check("rmid_fresh_rdata", bus.if_rdata, shadow[17]);
        @(negedge clock);

        // Data request dropped right after its grant.
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
        n = 0; k_dm = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 1) bus.dm_req = 1'b0;
            if (bus.dm_ack) begin n++; k_dm = k; end
        end
        check("drop_ack_count", 32'(n), 32'd1);
        check("drop_ack_time", 32'(k_dm), LAT + 2);
        check("drop_dm_rdata", bus.dm_rdata, shadow[16]);
        do_access('{1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0}, lat, nr, nw, no, sa, sw);
        check("drop_next_lat", 32'(lat), LAT + 2);
        check("drop_next_rdata", bus.if_rdata, shadow[16]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
